// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
// Captures the nine result words of the 3x3 multiplier on its done pulse and
// streams them one per beat over valid/ready, in row- or column-major order.
//
// Handshake: a beat transfers on a rising edge where m_valid && m_ready.
// m_valid stays high until that edge. m_data, m_index and m_last are stable
// while m_valid is high and m_ready is low. Every output comes straight from
// a register, so there is no combinational path from m_ready to any output.
// busy mirrors the FSM state (1 = STREAM).
module matrix_result_streamer #(
   parameter int DATA_W = 16,
   parameter int N      = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     done_in,
   input  logic [N*N*DATA_W-1:0]    c_flat,
   input  logic                     col_major,
   output logic [DATA_W-1:0]        m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_last,
   output logic [3:0]               m_index,
   output logic                     busy,
   output logic                     overrun,
   input  logic                     clear_overrun
);

   localparam int         NN       = N * N;
   localparam logic [3:0] LAST_CNT = 4'(NN - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] shadow     [NN];
   logic [DATA_W-1:0] shadow_nxt [NN];
   logic              order_r, order_nxt;
   logic [3:0]        cnt, cnt_nxt, idx_nxt;
   logic              hs, capture, stray;

   // Beat number -> row-major element index for the selected order.
   function automatic logic [3:0] map_idx(input logic [3:0] c, input logic col);
      int ci;
      ci = int'(c);
      if (col) map_idx = 4'((ci % N) * N + ci / N);
      else     map_idx = c;
   endfunction

   // Next-state logic: capture, beat advance and end-of-stream handling.
   always_comb begin
      hs        = m_valid && m_ready;
      // A new matrix is taken when idle, or exactly as the final beat leaves.
      capture   = done_in && ((state == IDLE) || (hs && cnt == LAST_CNT));
      // Any other done pulse can only arrive mid-stream and is dropped.
      stray     = done_in && !capture;
      state_nxt = state;
      cnt_nxt   = cnt;
      order_nxt = order_r;
      for (int i = 0; i < NN; i++) shadow_nxt[i] = shadow[i];
      if (capture) begin
         state_nxt = STREAM;
         cnt_nxt   = '0;
         order_nxt = col_major;
         for (int i = 0; i < NN; i++) shadow_nxt[i] = c_flat[i*DATA_W +: DATA_W];
      end else if (hs) begin
         if (cnt == LAST_CNT) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + 4'd1;
         end
      end
      idx_nxt = map_idx(cnt_nxt, order_nxt);
   end

   // State, shadow storage and registered stream outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         order_r <= 1'b0;
         for (int i = 0; i < NN; i++) shadow[i] <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_index <= '0;
         m_last  <= 1'b0;
         busy    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         order_r <= order_nxt;
         for (int i = 0; i < NN; i++) shadow[i] <= shadow_nxt[i];
         m_valid <= (state_nxt == STREAM);
         busy    <= (state_nxt == STREAM);
         m_index <= (state_nxt == STREAM) ? idx_nxt : 4'd0;
         m_data  <= (state_nxt == STREAM) ? shadow_nxt[idx_nxt] : '0;
         m_last  <= (state_nxt == STREAM) && (cnt_nxt == LAST_CNT);
         // A dropped pulse wins over a clear in the same cycle.
         if (stray)              overrun <= 1'b1;
         else if (clear_overrun) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Testbench for matrix_result_streamer: table-driven stream order checks,
// hand-written corner sequences and a randomized run, all scored against a
// queue-based reference model of the expected beats.
module tb_matrix_result_streamer;

   localparam int DATA_W = 16;
   localparam int N      = 3;
   localparam int NN     = N * N;
   localparam int CW     = NN * DATA_W;
   localparam int BW     = DATA_W + 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              done_in, col_major, m_ready, clear_overrun;
   logic [CW-1:0]     c_flat;
   logic [DATA_W-1:0] m_data;
   logic              m_valid, m_last, busy, overrun;
   logic [3:0]        m_index;

   matrix_result_streamer #(.DATA_W(DATA_W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .done_in(done_in), .c_flat(c_flat),
      .col_major(col_major), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last), .m_index(m_index), .busy(busy),
      .overrun(overrun), .clear_overrun(clear_overrun)
   );

   // ---------------- scoreboard ----------------
   // Each expected beat is {data, index, last}.
   logic [BW-1:0] exp_q[$];
   logic          exp_ovr;
   int            checks = 0;
   int            errors = 0;
   int            beats  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] mk(input int base);
      logic [CW-1:0] m;
      m = '0;
      for (int k = 0; k < NN; k++) m[k*DATA_W +: DATA_W] = DATA_W'(base + k);
      return m;
   endfunction

   function automatic logic [CW-1:0] rnd_mat();
      logic [CW-1:0] m;
      m = '0;
      for (int k = 0; k < NN; k++) m[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      return m;
   endfunction

   // Reference model: a captured matrix becomes NN queued beats in stream order.
   task automatic model_push(input logic [CW-1:0] mat, input logic col);
      int idx;
      for (int k = 0; k < NN; k++) begin
         idx = col ? ((k % N) * N + k / N) : k;
         exp_q.push_back({mat[idx*DATA_W +: DATA_W], 4'(idx), (k == NN - 1)});
      end
   endtask

   task automatic compare_model();
      logic [BW-1:0] b;
      check("valid", m_valid, exp_q.size() != 0);
      check("busy", busy, exp_q.size() != 0);
      check("overrun", overrun, exp_ovr);
      if (exp_q.size() != 0) begin
         b = exp_q[0];
         check("data", m_data, b[BW-1:5]);
         check("index", m_index, b[4:1]);
         check("last", m_last, b[0]);
      end else begin
         check("last_idle", m_last, 1'b0);
      end
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge: drive inputs, advance the model across the
   // rising edge, then compare at the next falling edge.
   task automatic step(input logic d, input logic r, input logic clr,
                       input logic col, input logic [CW-1:0] mat);
      logic v, hs, last_hs;
      done_in       = d;
      m_ready       = r;
      clear_overrun = clr;
      col_major     = col;
      c_flat        = mat;
      if (m_valid && r) beats++;
      v       = exp_q.size() != 0;
      hs      = v && r;
      last_hs = hs && exp_q.size() == 1;
      if (hs) void'(exp_q.pop_front());
      if (d && (!v || last_hs)) model_push(mat, col);
      if (d && v && !last_hs) exp_ovr = 1'b1;
      else if (clr)           exp_ovr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && m_valid; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("drain_timeout", m_valid, 1'b0);
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic              col;
      logic [DATA_W-1:0] exp_data  [NN];
      logic [3:0]        exp_index [NN];
   } vec_t;

   vec_t vecs [2];

   initial begin
      int busy_cycles;

      vecs[0].col       = 1'b0;
      vecs[0].exp_data  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      vecs[0].exp_index = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
      vecs[1].col       = 1'b1;
      vecs[1].exp_data  = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
      vecs[1].exp_index = '{0, 3, 6, 1, 4, 7, 2, 5, 8};

      exp_ovr       = 1'b0;
      rst_n         = 1'b0;
      done_in       = 1'b0;
      col_major     = 1'b0;
      m_ready       = 1'b0;
      clear_overrun = 1'b0;
      c_flat        = '0;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst_valid", m_valid, 1'b0);
      check("rst_last", m_last, 1'b0);
      check("rst_data", m_data, 0);
      check("rst_index", m_index, 0);
      check("rst_busy", busy, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      rst_n = 1'b1;
      idle_steps(2);

      // Stream order table, m_ready held high; col_major toggles mid-stream
      for (int v = 0; v < 2; v++) begin
         busy_cycles = 0;
         step(1'b1, 1'b1, 1'b0, vecs[v].col, mk(1));
         for (int k = 0; k < NN; k++) begin
            check("tbl_valid", m_valid, 1'b1);
            check("tbl_data", m_data, vecs[v].exp_data[k]);
            check("tbl_index", m_index, vecs[v].exp_index[k]);
            check("tbl_last", m_last, k == NN - 1);
            if (busy) busy_cycles++;
            step(1'b0, 1'b1, 1'b0, ~vecs[v].col, '0);
         end
         check("tbl_busy_cycles", busy_cycles, NN);
         check("tbl_end_valid", m_valid, 1'b0);
         check("tbl_overrun", overrun, 1'b0);
         idle_steps(1);
      end

      // Backpressure on the fourth beat
      beats = 0;
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(1));
      idle_steps(3);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, '0);
         check("bp_data", m_data, 4);
         check("bp_index", m_index, 3);
         check("bp_valid", m_valid, 1'b1);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("bp_resume", m_data, 5);
      drain();
      check("bp_beats", beats, NN);

      // Overrun: stray pulses, clear, and clear colliding with a stray pulse
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(1));
      idle_steps(2);
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(10));
      check("ovr_set", overrun, 1'b1);
      check("ovr_data", m_data, 4);
      step(1'b0, 1'b1, 1'b1, 1'b0, '0);
      check("ovr_clear", overrun, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(10));
      step(1'b1, 1'b1, 1'b1, 1'b0, mk(10));
      check("ovr_set_wins", overrun, 1'b1);
      check("ovr_data7", m_data, 7);
      drain();
      step(1'b0, 1'b1, 1'b1, 1'b0, '0);
      check("ovr_idle_clear", overrun, 1'b0);

      // Back-to-back capture on the final handshake
      beats = 0;
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(1));
      idle_steps(NN - 1);
      check("b2b_last", m_last, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(10));
      check("b2b_valid", m_valid, 1'b1);
      check("b2b_data", m_data, 10);
      check("b2b_index", m_index, 0);
      drain();
      check("b2b_beats", beats, 2 * NN);
      check("b2b_overrun", overrun, 1'b0);

      // Asynchronous reset mid-stream
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(1));
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(10));
      idle_steps(3);
      check("mrst_pre_data", m_data, 5);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_valid", m_valid, 1'b0);
      check("mrst_last", m_last, 1'b0);
      check("mrst_busy", busy, 1'b0);
      check("mrst_overrun", overrun, 1'b0);
      exp_q.delete();
      exp_ovr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_steps(3);
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(20));
      check("mrst_first", m_data, 20);
      drain();

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), rnd_mat());
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Output side of the 3x3 matrix-multiply datapath.
- On the multiplier's one-cycle done pulse, captures all nine result words in a single cycle.
- Streams the words one per beat on a valid/ready interface to a downstream consumer (UART framer, FIFO or DMA).
- Frees the multiplier to start the next product while the previous result drains.

Parameters:
DATA_W, 16, width of each result element
N, 3, matrix dimension; stream length is N*N beats

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
done_in  input  1  one-cycle pulse from multiplier; c_flat valid in the same cycle
c_flat  input  N*N*DATA_W  result matrix, row-major, c11 at bits [DATA_W-1:0], c33 at MSBs
col_major  input  1  stream order select, sampled only at capture
m_data  output  DATA_W  current element
m_valid  output  1  m_data valid
m_ready  input  1  consumer accepts the beat when m_valid && m_ready at a rising edge
m_last  output  1  high with the final (N*N-th) beat
m_index  output  4  row-major index (0..N*N-1) of the element on m_data
busy  output  1  a matrix is held or streaming
overrun  output  1  sticky: done_in arrived while busy and was not accepted
clear_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (async assert, sync release): state IDLE, m_valid=0, m_last=0, m_data=0, m_index=0, busy=0, overrun=0, shadow registers=0.
- States: IDLE, STREAM.
- IDLE:
  - done_in=1 -> latch c_flat into nine shadow registers, latch col_major into order_r, beat counter=0, go to STREAM.
  - m_valid=1 from the next cycle, so latency is 1 clock from done_in to first valid beat.
- STREAM:
  - m_data = shadow[map(cnt)].
  - Row-major map: cnt. Col-major map: (cnt%N)*N + cnt/N.
  - m_index = map(cnt). m_last = (cnt == N*N-1).
- Handshake (m_valid && m_ready):
  - cnt < N*N-1: cnt increments.
  - cnt == N*N-1: return to IDLE, m_valid drops next cycle.
- Backpressure: while m_valid && !m_ready, m_data, m_index and m_last hold stable; m_valid never drops before the handshake.
- m_valid, m_data, m_index and m_last depend only on registered state; there is no combinational path from m_ready to any output.
- busy = (state == STREAM).
- Full stream with m_ready held high takes exactly N*N cycles with no bubbles.
- Back-to-back: if done_in coincides with the last-beat handshake, capture the new matrix, set cnt=0, stay in STREAM. The next cycle shows the new first beat with no gap, and overrun is not set.
- done_in in STREAM at any other time: ignored (shadow unchanged, stream unaffected), overrun <= 1.
- Overrun clear: overrun set and clear in the same cycle -> set wins.
- col_major changes during STREAM: no effect until the next capture.
- Reset mid-stream: outputs go to reset values immediately. The remaining beats are discarded, and nothing streams until the next done_in.
- Widths: no arithmetic on data; shadow registers are DATA_W wide. cnt and m_index are 4 bits, sufficient for N<=4; N>4 is unsupported.

Test Plan:
1. Row-major, m_ready=1:
   - Stimulus: c11..c33 = 1..9, done_in pulse.
   - Required: m_valid rises 1 cycle later; m_data 1,2,...,9 on consecutive cycles; m_index 0..8; m_last only on 9; busy high for exactly 9 cycles; overrun=0.
2. col_major=1, same matrix:
   - Required: m_data 1,4,7,2,5,8,3,6,9; m_index 0,3,6,1,4,7,2,5,8; m_last with 9.
3. Backpressure:
   - Stimulus: m_ready=0 for 3 cycles while the 4th beat (value 4) is presented.
   - Required: m_data=4, m_index=3, m_valid=1 hold for all 3 cycles; stream resumes 5..9; total beats exactly 9, no duplicates.
4. Overrun:
   - Stimulus: second done_in (matrix 10..18) at beat 3.
   - Required: overrun=1, stream continues 4..9 unchanged; clear_overrun pulse -> overrun=0 next cycle.
   - Stimulus: clear_overrun coincident with another stray done_in.
   - Required: overrun stays 1.
5. Back-to-back:
   - Stimulus: done_in (matrix 10..18) in the same cycle as the handshake of beat 9.
   - Required: the next cycle shows m_data=10 with m_valid=1; 18 beats total with no gap; overrun=0.
6. Reset mid-stream:
   - Stimulus: rst_n low asynchronously after beat 5.
   - Required: m_valid, m_last, busy and overrun go 0 immediately; after release m_valid stays 0 until a new done_in, then a full 9-beat stream starts from element c11.
